mem_arbiter: RTL and testbench

Round-robin arbiter and transaction sequencer that shares one `main_memory` port among `num_req_p` cache DMA requesters. It grants one requester per transaction and holds the grant for the whole transaction. A read is one request handshake followed by `block_width_p/dma_data_width_p` response beats. A write is that many write-beat handshakes. Read beats are routed back only to the granted requester.

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 26 ++
 rtl/mem_arbiter.sv | 142 ++++++++++++++
 tb/tb_mem_arbiter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the round-robin main-memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RD_WAIT = 2'd2
    } mem_arb_state_e;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned WORD_W = 32;

    // Counter widths must stay at least one bit, even for single-beat blocks.
    function automatic int unsigned max1(input int unsigned v);
        return (v < 1) ? 1 : v;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority select: first set request at or after prio,
// searching cyclically upward.
module rr_arbiter #(
    parameter  int unsigned num_req_p = 2,
    localparam int unsigned id_w_lp   = $clog2(num_req_p)
) (
    input  logic [num_req_p-1:0] req,
    input  logic [id_w_lp-1:0]   prio,
    output logic [id_w_lp-1:0]   gnt_id,
    output logic                 gnt_v
);

    always_comb begin
        gnt_id = '0;
        gnt_v  = 1'b0;
        for (int i = 0; i < int'(num_req_p); i++) begin
            for (int k = 0; k < int'(num_req_p); k++) begin
                if (!gnt_v && req[k] && (k == (int'(prio) + i) % int'(num_req_p))) begin
                    gnt_v  = 1'b1;
                    gnt_id = id_w_lp'(k);
                end
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one main-memory port among cache DMA requesters;
// the grant is held for a whole read (request + beats) or write burst.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter  int unsigned num_req_p        = 2,
    parameter  int unsigned dma_data_width_p = 2,
    parameter  int unsigned block_width_p    = 8,
    localparam int unsigned beats_lp         = block_width_p / dma_data_width_p,
    localparam int unsigned cnt_w_lp         = max1($clog2(beats_lp)),
    localparam int unsigned id_w_lp          = $clog2(num_req_p),
    localparam int unsigned beat_w_lp        = dma_data_width_p * WORD_W
) (
    input  logic                           clk_i,
    input  logic                           nreset_i,
    input  logic [num_req_p-1:0]           req_valid_i,
    output logic [num_req_p-1:0]           req_ready_o,
    input  logic [num_req_p-1:0]           req_we_i,
    input  logic [num_req_p*ADDR_W-1:0]    req_addr_i,
    input  logic [num_req_p*beat_w_lp-1:0] req_wdata_i,
    output logic [num_req_p-1:0]           resp_valid_o,
    output logic [beat_w_lp-1:0]           resp_data_o,
    output logic                           mem_valid_o,
    output logic                           mem_we_o,
    output logic [ADDR_W-1:0]              mem_addr_o,
    output logic [beat_w_lp-1:0]           mem_wdata_o,
    input  logic                           mem_ready_i,
    input  logic                           mem_valid_i,
    input  logic [beat_w_lp-1:0]           mem_data_i,
    output logic [id_w_lp-1:0]             grant_id_o
);

    mem_arb_state_e        state_q, state_d;
    logic [id_w_lp-1:0]    grant_q, grant_d;
    logic [id_w_lp-1:0]    prio_q, prio_d;
    logic [cnt_w_lp-1:0]   beat_q, beat_d;

    logic [id_w_lp-1:0]    arb_id;
    logic                  arb_v;
    logic [id_w_lp-1:0]    grant_nxt;
    logic                  sel_valid, sel_we, hs, last_beat;
    logic [ADDR_W-1:0]     sel_addr;
    logic [beat_w_lp-1:0]  sel_wdata;

    rr_arbiter #(.num_req_p(num_req_p)) u_rr (
        .req    (req_valid_i),
        .prio   (prio_q),
        .gnt_id (arb_id),
        .gnt_v  (arb_v)
    );

    always_comb begin
        sel_valid = 1'b0;
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int k = 0; k < int'(num_req_p); k++) begin
            if (grant_q == id_w_lp'(k)) begin
                sel_valid = req_valid_i[k];
                sel_we    = req_we_i[k];
                sel_addr  = req_addr_i[ADDR_W*k +: ADDR_W];
                sel_wdata = req_wdata_i[beat_w_lp*k +: beat_w_lp];
            end
        end
    end

    assign hs          = sel_valid & mem_ready_i;
    assign last_beat   = (beat_q == cnt_w_lp'(beats_lp - 1));
    assign grant_nxt   = (grant_q == id_w_lp'(num_req_p - 1)) ? '0 : grant_q + 1'b1;
    assign mem_addr_o  = sel_addr;
    assign mem_wdata_o = sel_wdata;
    assign resp_data_o = mem_data_i;
    assign grant_id_o  = grant_q;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        prio_d       = prio_q;
        beat_d       = beat_q;
        req_ready_o  = '0;
        resp_valid_o = '0;
        mem_valid_o  = 1'b0;
        mem_we_o     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (arb_v) begin
                    grant_d = arb_id;
                    beat_d  = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                mem_valid_o = sel_valid;
                mem_we_o    = sel_we;
                for (int k = 0; k < int'(num_req_p); k++) begin
                    req_ready_o[k] = (grant_q == id_w_lp'(k)) & mem_ready_i;
                end
                if (hs) begin
                    if (!sel_we) begin
                        state_d = RD_WAIT;
                        beat_d  = '0;
                    end else if (last_beat) begin
                        state_d = IDLE;
                        prio_d  = grant_nxt;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            RD_WAIT: begin
                // Response beats go only to the requester that owns the grant.
                for (int k = 0; k < int'(num_req_p); k++) begin
                    resp_valid_o[k] = (grant_q == id_w_lp'(k)) & mem_valid_i;
                end
                if (mem_valid_i) begin
                    if (last_beat) begin
                        state_d = IDLE;
                        prio_d  = grant_nxt;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            prio_q  <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            prio_q  <= prio_d;
            beat_q  <= beat_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a 4-beat instance and a single-beat instance.
module tb_mem_arbiter;

    logic         clk;
    logic         nreset;

    logic [1:0]   req_valid, req_we, req_ready, resp_valid;
    logic [63:0]  req_addr;
    logic [127:0] req_wdata;
    logic [63:0]  resp_data;
    logic         mem_valid_o, mem_we_o, mem_ready, mem_valid_in;
    logic [31:0]  mem_addr;
    logic [63:0]  mem_wdata, mem_data;
    logic [0:0]   grant_id;

    logic [1:0]   s_req_valid, s_req_we, s_req_ready, s_resp_valid;
    logic [63:0]  s_req_addr;
    logic [127:0] s_req_wdata;
    logic [63:0]  s_resp_data;
    logic         s_mem_valid_o, s_mem_we_o, s_mem_ready, s_mem_valid_in;
    logic [31:0]  s_mem_addr;
    logic [63:0]  s_mem_wdata, s_mem_data;
    logic [0:0]   s_grant_id;

    int checks   = 0;
    int failures = 0;

    mem_arbiter #(.num_req_p(2), .dma_data_width_p(2), .block_width_p(8)) dut (
        .clk_i(clk), .nreset_i(nreset),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .resp_valid_o(resp_valid), .resp_data_o(resp_data),
        .mem_valid_o(mem_valid_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_ready_i(mem_ready), .mem_valid_i(mem_valid_in),
        .mem_data_i(mem_data), .grant_id_o(grant_id)
    );

    mem_arbiter #(.num_req_p(2), .dma_data_width_p(2), .block_width_p(2)) dut1 (
        .clk_i(clk), .nreset_i(nreset),
        .req_valid_i(s_req_valid), .req_ready_o(s_req_ready), .req_we_i(s_req_we),
        .req_addr_i(s_req_addr), .req_wdata_i(s_req_wdata),
        .resp_valid_o(s_resp_valid), .resp_data_o(s_resp_data),
        .mem_valid_o(s_mem_valid_o), .mem_we_o(s_mem_we_o), .mem_addr_o(s_mem_addr),
        .mem_wdata_o(s_mem_wdata), .mem_ready_i(s_mem_ready), .mem_valid_i(s_mem_valid_in),
        .mem_data_i(s_mem_data), .grant_id_o(s_grant_id)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Caller leaves dut in IDLE with requester id valid on a read of addr.
    task automatic read_txn(input int id, input logic [31:0] addr, input int stall,
                            input int nbeats, input bit keep);
        logic [1:0] onehot;
        onehot    = 2'b01 << id;
        mem_ready = (stall == 0);
        tick();
        for (int s = 0; s < stall; s++) begin
            #1;
            check("bp_ready", req_ready, 2'b00);
            check("bp_mvalid", mem_valid_o, 1'b1);
            check("bp_addr", mem_addr, addr);
            tick();
        end
        mem_ready = 1'b1;
        #1;
        check("rd_gid", grant_id, id);
        check("rd_mvalid", mem_valid_o, 1'b1);
        check("rd_we", mem_we_o, 1'b0);
        check("rd_addr", mem_addr, addr);
        check("rd_ready", req_ready, onehot);
        tick();
        if (!keep) req_valid[id] = 1'b0;
        mem_valid_in = 1'b0;
        #1;
        check("rw_mvalid", mem_valid_o, 1'b0);
        check("rw_noresp", resp_valid, 2'b00);
        for (int b = 0; b < nbeats; b++) begin
            mem_valid_in = 1'b1;
            mem_data     = {addr, 32'(b)};
            #1;
            check("rd_resp_v", resp_valid, onehot);
            check("rd_resp_d", resp_data, {addr, 32'(b)});
            tick();
        end
        if (nbeats == 4) begin
            mem_data = 64'hDEAD_BEEF_0000_0000;
            #1;
            check("end_resp", resp_valid, 2'b00);
            check("end_mvalid", mem_valid_o, 1'b0);
            check("end_ready", req_ready, 2'b00);
            mem_valid_in = 1'b0;
        end
    endtask

    initial begin
        nreset = 1'b0;
        req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        mem_ready = 1'b0; mem_valid_in = 1'b0; mem_data = '0;
        s_req_valid = '0; s_req_we = '0; s_req_addr = '0; s_req_wdata = '0;
        s_mem_ready = 1'b0; s_mem_valid_in = 1'b0; s_mem_data = '0;
        #1;
        check("rst_ready", req_ready, 2'b00);
        check("rst_resp", resp_valid, 2'b00);
        check("rst_mvalid", mem_valid_o, 1'b0);
        check("rst_we", mem_we_o, 1'b0);
        check("rst_gid", grant_id, 1'b0);
        check("rst1_mvalid", s_mem_valid_o, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        nreset = 1'b1;

        // Single read from requester 0.
        req_valid = 2'b01;
        req_addr[31:0] = 32'h40;
        #1;
        check("idle_mvalid", mem_valid_o, 1'b0);
        read_txn(0, 32'h40, 0, 4, 1'b0);

        // Simultaneous reads after reset: 0, then 1, then 0 again.
        nreset = 1'b0;
        #1;
        nreset = 1'b1;
        req_valid = 2'b11;
        req_addr  = {32'h200, 32'h100};
        read_txn(0, 32'h100, 0, 4, 1'b1);
        read_txn(1, 32'h200, 0, 4, 1'b0);
        read_txn(0, 32'h100, 0, 4, 1'b0);

        // Write burst by requester 1 while requester 0 waits.
        req_valid = 2'b11;
        req_we    = 2'b10;
        req_addr  = {32'h80, 32'h300};
        mem_ready = 1'b1;
        tick();
        for (int b = 0; b < 4; b++) begin
            req_addr[63:32]   = 32'h80 + 32'(8 * b);
            req_wdata[127:64] = {32'hC0DE_0000 + 32'(b), 32'(b)};
            #1;
            check("wr_mvalid", mem_valid_o, 1'b1);
            check("wr_we", mem_we_o, 1'b1);
            check("wr_addr", mem_addr, 32'h80 + 32'(8 * b));
            check("wr_data", mem_wdata, {32'hC0DE_0000 + 32'(b), 32'(b)});
            check("wr_ready", req_ready, 2'b10);
            tick();
        end
        req_valid[1] = 1'b0;
        req_we       = 2'b00;
        #1;
        check("wr_end_mvalid", mem_valid_o, 1'b0);
        check("wr_end_ready", req_ready, 2'b00);

        // Backpressure on requester 0 read.
        read_txn(0, 32'h300, 3, 4, 1'b0);

        // Reset in RD_WAIT after beat 1 of a requester-1 read.
        req_valid[1]    = 1'b1;
        req_addr[63:32] = 32'h400;
        read_txn(1, 32'h400, 0, 2, 1'b0);
        mem_valid_in = 1'b1;
        mem_data     = 64'h1234_5678_9ABC_DEF0;
        #1;
        check("pre_rst_resp", resp_valid, 2'b10);
        nreset = 1'b0;
        #1;
        check("mid_rst_resp", resp_valid, 2'b00);
        check("mid_rst_ready", req_ready, 2'b00);
        check("mid_rst_mvalid", mem_valid_o, 1'b0);
        check("mid_rst_we", mem_we_o, 1'b0);
        check("mid_rst_gid", grant_id, 1'b0);
        #2;
        nreset = 1'b1;
        tick();
        check("stray_resp", resp_valid, 2'b00);
        check("stray_mvalid", mem_valid_o, 1'b0);
        tick();
        check("stray_resp2", resp_valid, 2'b00);
        mem_valid_in = 1'b0;

        // Single-beat instance: one-beat read, then one-handshake write.
        s_req_valid = 2'b01;
        s_req_addr  = {32'h600, 32'h500};
        s_mem_ready = 1'b1;
        tick();
        check("sb_rd_mvalid", s_mem_valid_o, 1'b1);
        check("sb_rd_ready", s_req_ready, 2'b01);
        tick();
        s_req_valid    = 2'b00;
        s_mem_valid_in = 1'b1;
        s_mem_data     = 64'hAAAA_5555_0F0F_F0F0;
        #1;
        check("sb_rd_resp", s_resp_valid, 2'b01);
        check("sb_rd_data", s_resp_data, 64'hAAAA_5555_0F0F_F0F0);
        tick();
        check("sb_rd_done", s_resp_valid, 2'b00);
        s_mem_valid_in = 1'b0;
        s_req_valid    = 2'b10;
        s_req_we       = 2'b10;
        s_req_wdata[127:64] = 64'h0BAD_F00D_CAFE_0001;
        tick();
        check("sb_wr_gid", s_grant_id, 1'b1);
        check("sb_wr_we", s_mem_we_o, 1'b1);
        check("sb_wr_ready", s_req_ready, 2'b10);
        check("sb_wr_data", s_mem_wdata, 64'h0BAD_F00D_CAFE_0001);
        tick();
        check("sb_wr_done", s_mem_valid_o, 1'b0);
        check("sb_wr_done_rdy", s_req_ready, 2'b00);
        s_req_valid = 2'b00;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
